// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous SRAM among NUM_REQ requesters.
// Read tags travel down a shift register so each response returns to its requester at fixed latency.
module sram_arbiter #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned ADDR_WIDTH   = 4,
  parameter int unsigned NUM_REQ      = 2,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic                          sram_cs,
  output logic                          sram_we,
  output logic [ADDR_WIDTH-1:0]         sram_addr,
  output logic [DATA_WIDTH-1:0]         sram_din,
  input  logic [DATA_WIDTH-1:0]         sram_dout,
  output logic                          busy
);

  localparam int unsigned ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned DEPTH = READ_LATENCY + 1;

  logic [ID_W-1:0]       ptr_q, ptr_d;
  logic [ID_W-1:0]       grant_id;
  logic [ID_W-1:0]       cand;
  logic                  grant;

  logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
  logic [DATA_WIDTH-1:0] wdata_arr [NUM_REQ];

  logic                  cs_q, cs_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;

  logic [DEPTH-1:0]      tag_vld_q, tag_vld_d;
  logic [DEPTH*ID_W-1:0] tag_id_q, tag_id_d;
  logic [ID_W-1:0]       rsp_id;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_arr[g]  = req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_arr[g] = req_wdata[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // First valid requester found scanning upward from the pointer, wrapping.
  always_comb begin
    grant     = 1'b0;
    grant_id  = '0;
    cand      = '0;
    req_ready = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = ID_W'((ptr_q + k) % NUM_REQ);
      if (!grant && req_valid[cand]) begin
        grant    = 1'b1;
        grant_id = cand;
      end
    end
    if (rst) begin
      grant = 1'b0;
    end
    if (grant) begin
      req_ready[grant_id] = 1'b1;
    end
  end

  always_comb begin
    ptr_d  = ptr_q;
    cs_d   = grant;
    we_d   = 1'b0;
    addr_d = addr_q;
    din_d  = din_q;
    if (grant) begin
      ptr_d  = (32'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + 1'b1;
      we_d   = req_we[grant_id];
      addr_d = addr_arr[grant_id];
      din_d  = req_we[grant_id] ? wdata_arr[grant_id] : '0;
    end
  end

  // Stage 0 is loaded at the accept edge; the last stage lines up with valid sram_dout.
  always_comb begin
    tag_vld_d = {tag_vld_q[DEPTH-2:0], grant & ~req_we[grant_id]};
    tag_id_d  = {tag_id_q[(DEPTH-1)*ID_W-1:0], grant_id};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q     <= '0;
      cs_q      <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      din_q     <= '0;
      tag_vld_q <= '0;
      tag_id_q  <= '0;
    end else begin
      ptr_q     <= ptr_d;
      cs_q      <= cs_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      din_q     <= din_d;
      tag_vld_q <= tag_vld_d;
      tag_id_q  <= tag_id_d;
    end
  end

  assign rsp_id = tag_id_q[(DEPTH-1)*ID_W +: ID_W];

  always_comb begin
    rsp_valid = '0;
    if (tag_vld_q[DEPTH-1]) begin
      rsp_valid[rsp_id] = 1'b1;
    end
  end

  assign rsp_data  = sram_dout;
  assign busy      = |tag_vld_q;
  assign sram_cs   = cs_q;
  assign sram_we   = we_q;
  assign sram_addr = addr_q;
  assign sram_din  = din_q;

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Round-robin arbiter that shares a single-port synchronous SRAM (cs/we/addr/din/dout, 1-cycle registered read) between NUM_REQ requesters, e.g. the vocab/weight loader and the tensor-core operand fetchers.
- Accepts one request per cycle with a valid/ready handshake and drives the SRAM port from registers.
- Tags each read and returns its data to the originating requester with a fixed latency.
- Writes are posted and produce no response.

Parameters:
- DATA_WIDTH, 8, SRAM word width.
- ADDR_WIDTH, 4, SRAM address width.
- NUM_REQ, 2, number of requesters (>=2).
- READ_LATENCY, 1, SRAM cycles from address sample to valid dout.

Ports:
- clk  in  1  system clock, all logic on posedge
- rst  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester grant/accept (one-hot or zero)
- req_we  in  NUM_REQ  1=write, 0=read, per requester
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data
- rsp_valid  out  NUM_REQ  one-cycle pulse: read data for requester i present on rsp_data
- rsp_data  out  DATA_WIDTH  read data, shared by all requesters
- sram_cs  out  1  SRAM chip select
- sram_we  out  1  SRAM write enable
- sram_addr  out  ADDR_WIDTH  SRAM address
- sram_din  out  DATA_WIDTH  SRAM write data
- sram_dout  in  DATA_WIDTH  SRAM read data
- busy  out  1  high while any read is in flight

Behaviour:
- Reset (rst high at posedge):
  - sram_cs=0, sram_we=0, sram_addr=0, sram_din=0; rsp_valid=0; busy=0.
  - RR pointer = 0, so requester 0 has highest priority.
  - In-flight read tags are cleared; no rsp_valid fires for reads accepted before reset.
  - req_ready=0 whenever rst=1.
- Grant (combinational):
  - Scan from the pointer upward, wrapping modulo NUM_REQ; the first i with req_valid[i]=1 gets req_ready[i]=1.
  - At most one ready bit per cycle; req_ready never asserts for an invalid request.
- Accept: req_valid[i] & req_ready[i] at posedge E0.
  - At E0, register sram_cs=1, sram_we=req_we[i], sram_addr, sram_din (sram_din=0 for reads).
  - Pointer becomes (i+1) mod NUM_REQ; pointer holds when nothing is accepted.
- No accept at E0: sram_cs=0, sram_we=0, addr/din hold their previous values.
- Throughput: back-to-back accepts every cycle; no bubbles.
- Read pipeline:
  - Tag shift register of depth READ_LATENCY+1 carries {valid, id}.
  - The SRAM samples at E1 and dout is valid after E1+READ_LATENCY-1.
  - rsp_valid[id] pulses for exactly one cycle, READ_LATENCY+1 cycles after E0. With the default, that is the cycle between E2-1 and E2: data seen at E2.
  - rsp_data = sram_dout combinationally; it is only meaningful while any rsp_valid is high.
  - Responses return in acceptance order. There is no response backpressure: requesters must always sink rsp.
- Writes: tag valid=0, so no response.
  - Write at E0 followed by a read of the same address at E1 returns the new data.
- busy = OR of tag valid bits.
- A requester may hold req_valid with changing we/addr/wdata until accepted; values are sampled only at the accepting edge.
- Fairness: with all requesters continuously valid, grants rotate 0,1,...,NUM_REQ-1,0,...
- Any requester waits at most NUM_REQ-1 accepts.

Test Plan:
- Reset: hold rst 3 cycles with req_valid=2'b11 -> req_ready=0, sram_cs=0, rsp_valid=0, busy=0 throughout; after release the first grant goes to req0.
- Single read: preload mem[5]=8'hA5; req1 reads addr 5 -> accepted same cycle; sram_cs=1, we=0, addr=5 the next cycle; rsp_valid=2'b10 with rsp_data=8'hA5 two cycles after acceptance, for one cycle only.
- Contention: both requesters valid for 6 cycles, reading addr 0 (req0) and 1 (req1) -> grants alternate 0,1,0,1,0,1; responses alternate with mem[0]/mem[1] data in acceptance order.
- Write then read: req0 writes 8'h3C to addr 15, then req1 reads addr 15 the next cycle -> rsp_valid[1] with rsp_data=8'h3C; no rsp_valid for the write.
- Streaming: req0 reads addr 0..15 back-to-back with req1 idle -> 16 consecutive rsp_valid[0] pulses, data matching the init image in order; busy high throughout and low 2 cycles after the last accept.
- Reset mid-flight: accept a read, assert rst the next cycle -> no rsp_valid is ever produced for that read; after reset the pointer is 0.
